// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage with a control/data payload split.
// Supports flush, bubble kill of control bits, an optional skid entry and a saturating flush counter.
module pipe_stage_reg #(
    parameter int                 DATA_W         = 128,
    parameter int                 CTRL_W         = 16,
    parameter logic [CTRL_W-1:0]  CTRL_KILL_MASK = {CTRL_W{1'b1}},
    parameter int                 SKID           = 1,
    parameter int                 CNT_W          = 16
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              accept;
    logic              pop;
    logic [1:0]        held;
    logic [CTRL_W-1:0] in_ctrl_eff;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] n);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, n};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // With a skid entry, in_ready depends only on state, so out_ready never reaches upstream.
    assign in_ready    = (SKID != 0) ? !s_valid_q : (!m_valid_q || out_ready);
    assign accept      = in_valid & in_ready;
    assign pop         = m_valid_q & out_ready;
    assign held        = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    assign in_ctrl_eff = bubble ? (in_ctrl & ~CTRL_KILL_MASK) : in_ctrl;

    always_comb begin
        m_valid_d   = m_valid_q;
        m_ctrl_d    = m_ctrl_q;
        m_data_d    = m_data_q;
        s_valid_d   = s_valid_q;
        s_ctrl_d    = s_ctrl_q;
        s_data_d    = s_data_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            m_valid_d   = 1'b0;
            m_ctrl_d    = '0;
            m_data_d    = '0;
            s_valid_d   = 1'b0;
            s_ctrl_d    = '0;
            s_data_d    = '0;
            flush_cnt_d = sat_add(flush_cnt_q, held);
        end else if (SKID != 0) begin
            if (!m_valid_q || pop) begin
                // The skid entry is older than anything offered now, so it drains first.
                if (s_valid_q) begin
                    m_valid_d = 1'b1;
                    m_ctrl_d  = s_ctrl_q;
                    m_data_d  = s_data_q;
                    s_valid_d = 1'b0;
                end else if (accept) begin
                    m_valid_d = 1'b1;
                    m_ctrl_d  = in_ctrl_eff;
                    m_data_d  = in_data;
                end else begin
                    m_valid_d = 1'b0;
                end
            end else if (accept) begin
                s_valid_d = 1'b1;
                s_ctrl_d  = in_ctrl_eff;
                s_data_d  = in_data;
            end
        end else begin
            if (accept) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = in_ctrl_eff;
                m_data_d  = in_data;
            end else if (pop) begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(negedge Clk) begin
        if (Clr) begin
            m_valid_q   <= 1'b0;
            m_ctrl_q    <= '0;
            m_data_q    <= '0;
            s_valid_q   <= 1'b0;
            s_ctrl_q    <= '0;
            s_data_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_ctrl_q    <= m_ctrl_d;
            m_data_q    <= m_data_d;
            s_valid_q   <= s_valid_d;
            s_ctrl_q    <= s_ctrl_d;
            s_data_q    <= s_data_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign occupancy = held;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share one stimulus stream
// and are each compared against a queue-based model of the stage.
module tb_pipe_stage_reg;

    localparam int              DW   = 32;
    localparam int              CW   = 16;
    localparam int              NW   = 4;
    localparam logic [CW-1:0]   MASK = 16'h00FF;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          Clk = 1'b0;
    logic          Clr, in_valid, bubble, flush, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          rdy [2];
    logic          ov  [2];
    logic [CW-1:0] oc  [2];
    logic [DW-1:0] od  [2];
    logic [1:0]    occ [2];
    logic [NW-1:0] fc  [2];

    int   n_chk = 0;
    int   n_err = 0;
    ent_t mq [2][$];
    int   mcnt [2];

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_KILL_MASK(MASK), .SKID(1), .CNT_W(NW)) u_dut_skid (
        .Clk(Clk), .Clr(Clr), .in_valid(in_valid), .in_ready(rdy[0]), .in_ctrl(in_ctrl),
        .in_data(in_data), .bubble(bubble), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
        .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0]), .flush_cnt(fc[0]));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_KILL_MASK(MASK), .SKID(0), .CNT_W(NW)) u_dut_noskid (
        .Clk(Clk), .Clr(Clr), .in_valid(in_valid), .in_ready(rdy[1]), .in_ctrl(in_ctrl),
        .in_data(in_data), .bubble(bubble), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
        .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1]), .flush_cnt(fc[1]));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instance 0 holds up to two entries; instance 1 holds one but can swap on a pop.
    function automatic bit m_ready(input int k);
        if (k == 0) return mq[k].size() < 2;
        return (mq[k].size() == 0) || out_ready;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (Clr) begin
                mq[k].delete();
                mcnt[k] = 0;
            end else if (flush) begin
                mcnt[k] = mcnt[k] + mq[k].size();
                if (mcnt[k] > (1 << NW) - 1) mcnt[k] = (1 << NW) - 1;
                mq[k].delete();
            end else begin
                bit   acc;
                ent_t e;
                acc = in_valid && m_ready(k);
                if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
                if (acc) begin
                    e.c = bubble ? (in_ctrl & ~MASK) : in_ctrl;
                    e.d = in_data;
                    mq[k].push_back(e);
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.in_ready%0d", tag, k), 128'(rdy[k]), 128'(m_ready(k)));
            check($sformatf("%s.out_valid%0d", tag, k), 128'(ov[k]), 128'(mq[k].size() > 0));
            check($sformatf("%s.occupancy%0d", tag, k), 128'(occ[k]), 128'(mq[k].size()));
            check($sformatf("%s.flush_cnt%0d", tag, k), 128'(fc[k]), 128'(mcnt[k]));
            if (mq[k].size() > 0) begin
                check($sformatf("%s.out_ctrl%0d", tag, k), 128'(oc[k]), 128'(mq[k][0].c));
                check($sformatf("%s.out_data%0d", tag, k), 128'(od[k]), 128'(mq[k][0].d));
            end
        end
    endtask

    // Entered at a rising edge with inputs driven; leaves at the next rising edge.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        @(negedge Clk);
        model_edge();
        @(posedge Clk);
    endtask

    task automatic offer(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        Clr = 1'b1; in_valid = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        mcnt[0] = 0; mcnt[1] = 0;
        repeat (2) @(negedge Clk);
        @(posedge Clk);
        check("rst_out_ctrl", 128'(oc[0]), 128'h0);
        check("rst_out_data", 128'(od[0]), 128'h0);
        tick("rst");
        Clr = 1'b0;

        // Streaming at full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(1'b1, CW'(i), DW'(i * 16));
            tick("stream");
            check("stream_occ", 128'(occ[0]), 128'd1);
        end
        offer(1'b0, '0, '0);
        tick("drain");

        // Backpressure fills main and skid, C refused
        out_ready = 1'b0;
        offer(1'b1, 16'h000A, 32'hA0); tick("bp_a");
        offer(1'b1, 16'h000B, 32'hB0); tick("bp_b");
        offer(1'b1, 16'h000C, 32'hC0); tick("bp_c");
        check("bp_full_occ", 128'(occ[0]), 128'd2);
        check("bp_full_rdy", 128'(rdy[0]), 128'd0);
        check("bp_head", 128'(oc[0]), 128'h000A);
        out_ready = 1'b1;
        tick("bp_c2");
        offer(1'b0, '0, '0);
        repeat (3) tick("bp_drain");

        // Bubble kills the low control byte only
        offer(1'b1, 16'hABCD, 32'h1234);
        bubble = 1'b1;
        tick("bubble");
        bubble = 1'b0;
        offer(1'b0, '0, '0);
        out_ready = 1'b0;
        check("bubble_ctrl", 128'(oc[0]), 128'hAB00);
        check("bubble_data", 128'(od[0]), 128'h1234);
        check("bubble_valid", 128'(ov[0]), 128'd1);
        tick("bubble_hold");

        // Flush with two held entries and a simultaneous offer
        offer(1'b1, 16'h0011, 32'h11); tick("fl_fill");
        offer(1'b1, 16'h0022, 32'h22);
        flush = 1'b1;
        tick("flush");
        flush = 1'b0;
        check("flush_valid", 128'(ov[0]), 128'd0);
        check("flush_occ", 128'(occ[0]), 128'd0);
        check("flush_ctrl", 128'(oc[0]), 128'h0);
        check("flush_data", 128'(od[0]), 128'h0);
        check("flush_cnt", 128'(fc[0]), 128'd2);
        for (int r = 0; r < 7; r++) begin
            offer(1'b1, CW'(r), DW'(r)); tick("sat_fill");
            tick("sat_fill2");
            flush = 1'b1; tick("sat_flush");
            flush = 1'b0;
        end
        check("flush_sat", 128'(fc[0]), 128'hF);

        // Clear mid-operation
        offer(1'b1, 16'h0033, 32'h33); tick("clr_fill");
        tick("clr_fill2");
        Clr = 1'b1;
        offer(1'b0, '0, '0);
        tick("clr");
        Clr = 1'b0;
        check("clr_valid", 128'(ov[0]), 128'd0);
        check("clr_occ", 128'(occ[0]), 128'd0);
        check("clr_cnt", 128'(fc[0]), 128'd0);
        check("clr_rdy", 128'(rdy[0]), 128'd1);

        // Single-register stage: combinational ready and replace-on-pop
        out_ready = 1'b0;
        offer(1'b1, 16'h0044, 32'h44); tick("s0_x");
        offer(1'b1, 16'h0055, 32'h55);
        #1 check("s0_full_rdy", 128'(rdy[1]), 128'd0);
        tick("s0_y");
        out_ready = 1'b1;
        offer(1'b1, 16'h0066, 32'h66);
        #1 check("s0_comb_rdy", 128'(rdy[1]), 128'd1);
        tick("s0_z");
        check("s0_replace", 128'(oc[1]), 128'h0066);
        offer(1'b0, '0, '0);
        repeat (3) tick("s0_drain");

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            bubble    = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            Clr       = ($urandom_range(0, 199) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = $urandom;
            tick("rnd");
        end
        Clr = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick("end");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
